// File: rtl/core_pipe_ctrl_if.sv
// Handshake bundle between the i2d pipeline and its control unit.
// The master drives stall/exception requests; the slave returns halt/flush/redirect.
interface core_pipe_ctrl_if #(
  parameter int NSTAGE = 4
);
  localparam int SW = $clog2(NSTAGE);

  logic              mau_busy;
  logic [NSTAGE-1:0] stall_req;
  logic              except;
  logic [SW-1:0]     except_stage;
  logic [NSTAGE-1:0] halt;
  logic [NSTAGE-1:0] flush;
  logic              redirect;
  logic              except_busy;
  logic              stall_timeout;

  modport master (
    output mau_busy, stall_req, except, except_stage,
    input  halt, flush, redirect, except_busy, stall_timeout
  );

  modport slave (
    input  mau_busy, stall_req, except, except_stage,
    output halt, flush, redirect, except_busy, stall_timeout
  );
endinterface

// File: rtl/core_pipe_ctrl.sv
// Pipeline halt/flush control for the i2d core with an exception flush sequencer.
// Optional stall watchdog enabled by defining CORE_PIPE_CTRL_WDOG_EN.
module core_pipe_ctrl #(
  parameter int NSTAGE     = 4,
  parameter int FLUSH_CYC  = 1,
  parameter int WDOG_LIMIT = 1023
) (
  input  logic                    clk,
  input  logic                    rst_n,
  core_pipe_ctrl_if.slave         bus
);
  localparam int SW = $clog2(NSTAGE);
  localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [SW-1:0] LAST_IDX = SW'(NSTAGE - 1);
  localparam logic [FW-1:0] FCNT_LOAD = FW'(FLUSH_CYC - 1);

  if (NSTAGE < 2 || FLUSH_CYC < 1 || WDOG_LIMIT < 1) begin : g_param_check
    $error("core_pipe_ctrl: illegal parameter value");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FLUSH} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] ks_q, ks_d;
  logic [FW-1:0] fcnt_q, fcnt_d;

  logic [NSTAGE-1:0] hreq;
  logic [NSTAGE-1:0] flush_w;
  logic [NSTAGE-1:0] halt_w;
  logic [SW-1:0]     stage_clamped;

  assign stage_clamped = (bus.except_stage > LAST_IDX) ? LAST_IDX : bus.except_stage;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ks_q    <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ks_q    <= ks_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ks_d    = ks_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.except) begin
          ks_d = stage_clamped;
          if (bus.mau_busy) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_FLUSH;
            fcnt_d  = FCNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (!bus.mau_busy) begin
          state_d = S_FLUSH;
          fcnt_d  = FCNT_LOAD;
        end
      end
      S_FLUSH: begin
        // Memory activity cannot stretch the flush once it has started.
        if (fcnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          fcnt_d = fcnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Flush/redirect/busy decode only from flops, so input glitches never reach them.
  genvar gi;
  generate
    for (gi = 0; gi < NSTAGE; gi++) begin : g_stage
      assign hreq[gi]    = bus.mau_busy | (|bus.stall_req[NSTAGE-1:gi]);
      assign flush_w[gi] = (state_q == S_FLUSH) && (ks_q >= SW'(gi));
      assign halt_w[gi]  = rst_n & hreq[gi] & ~flush_w[gi];
    end
  endgenerate

  assign bus.halt        = halt_w;
  assign bus.flush       = flush_w;
  assign bus.redirect    = (state_q == S_FLUSH) && (fcnt_q == '0);
  assign bus.except_busy = (state_q != S_IDLE);

`ifdef CORE_PIPE_CTRL_WDOG_EN
  localparam int WW = $clog2(WDOG_LIMIT + 1);
  localparam logic [WW-1:0] WLIM = WW'(WDOG_LIMIT);

  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          timeout_q, timeout_d;

  always_comb begin
    wcnt_d = '0;
    if (halt_w[0]) begin
      wcnt_d = (wcnt_q == WLIM) ? wcnt_q : wcnt_q + 1'b1;
    end
    timeout_d = timeout_q | (wcnt_d == WLIM);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wcnt_q    <= wcnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.stall_timeout = timeout_q;
`else
  assign bus.stall_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_core_pipe_ctrl.sv
// Directed bench for core_pipe_ctrl (NSTAGE=4, FLUSH_CYC=2, WDOG_LIMIT=8).
module tb_core_pipe_ctrl;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  core_pipe_ctrl_if #(.NSTAGE(4)) bus ();

  core_pipe_ctrl #(
    .NSTAGE(4),
    .FLUSH_CYC(2),
    .WDOG_LIMIT(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] h, input logic [3:0] f,
                         input logic r, input logic b);
    chk({tag, ".halt"},  32'(bus.halt),        32'(h));
    chk({tag, ".flush"}, 32'(bus.flush),       32'(f));
    chk({tag, ".redir"}, 32'(bus.redirect),    32'(r));
    chk({tag, ".busy"},  32'(bus.except_busy), 32'(b));
    $display("[TB] %s halt=%b flush=%b redirect=%b busy=%b", tag, bus.halt, bus.flush,
             bus.redirect, bus.except_busy);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n            = 1'b0;
    bus.mau_busy     = 1'b0;
    bus.stall_req    = 4'b1111;
    bus.except       = 1'b0;
    bus.except_stage = 2'd0;
    step();
    step();
    chk_out("reset", 4'b0000, 4'b0000, 1'b0, 1'b0);
    chk("reset.timeout", 32'(bus.stall_timeout), 32'h0);

    bus.stall_req = 4'b0000;
    rst_n = 1'b1;
    step();

    // Combinational halt propagation
    bus.stall_req = 4'b0100; #1;
    chk_out("idle_0100", 4'b0111, 4'b0000, 1'b0, 1'b0);
    bus.stall_req = 4'b0001; #1;
    chk_out("idle_0001", 4'b0001, 4'b0000, 1'b0, 1'b0);
    bus.stall_req = 4'b1000; #1;
    chk_out("idle_1000", 4'b1111, 4'b0000, 1'b0, 1'b0);
    bus.stall_req = 4'b0000; #1;
    chk_out("idle_none", 4'b0000, 4'b0000, 1'b0, 1'b0);

    // MAU stall halts everything, FSM untouched
    bus.mau_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk_out($sformatf("mau_%0d", i), 4'b1111, 4'b0000, 1'b0, 1'b0);
      step();
    end
    bus.mau_busy = 1'b0; #1;
    chk_out("mau_off", 4'b0000, 4'b0000, 1'b0, 1'b0);

    // Exception at stage 2, FLUSH_CYC=2
    bus.except = 1'b1; bus.except_stage = 2'd2;
    step();
    bus.except = 1'b0;
    chk_out("exc_t1", 4'b0000, 4'b0111, 1'b0, 1'b1);
    step();
    chk_out("exc_t2", 4'b0000, 4'b0111, 1'b1, 1'b1);
    // raised on the returning cycle: must be ignored
    bus.except = 1'b1; bus.except_stage = 2'd0;
    step();
    bus.except = 1'b0;
    chk_out("exc_t3", 4'b0000, 4'b0000, 1'b0, 1'b0);
    step();
    chk_out("exc_t4", 4'b0000, 4'b0000, 1'b0, 1'b0);

    // Deferred exception at stage 1 behind MAU busy
    bus.mau_busy = 1'b1; bus.except = 1'b1; bus.except_stage = 2'd1;
    step();
    bus.except_stage = 2'd3;  // second request during WAIT
    #1;
    chk_out("wait_1", 4'b1111, 4'b0000, 1'b0, 1'b1);
    step();
    bus.except = 1'b0;
    chk_out("wait_2", 4'b1111, 4'b0000, 1'b0, 1'b1);
    step();
    chk_out("wait_3", 4'b1111, 4'b0000, 1'b0, 1'b1);
    step();
    bus.mau_busy = 1'b0; #1;
    chk_out("wait_4", 4'b0000, 4'b0000, 1'b0, 1'b1);
    step();
    chk_out("defl_1", 4'b0000, 4'b0011, 1'b0, 1'b1);
    // Flush dominates halt; MAU busy does not extend the flush
    bus.stall_req = 4'b1000; bus.mau_busy = 1'b1; #1;
    chk_out("dom_1", 4'b1100, 4'b0011, 1'b0, 1'b1);
    step();
    chk_out("dom_2", 4'b1100, 4'b0011, 1'b1, 1'b1);
    step();
    chk_out("dom_3", 4'b1111, 4'b0000, 1'b0, 1'b0);
    bus.stall_req = 4'b0000; bus.mau_busy = 1'b0;
    step();

    // Reset mid-FLUSH aborts with no redirect
    bus.except = 1'b1; bus.except_stage = 2'd3;
    step();
    bus.except = 1'b0;
    chk_out("rflush_1", 4'b0000, 4'b1111, 1'b0, 1'b1);
    rst_n = 1'b0;
    step();
    chk_out("rflush_rst", 4'b0000, 4'b0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    chk_out("rflush_a1", 4'b0000, 4'b0000, 1'b0, 1'b0);
    step();
    chk_out("rflush_a2", 4'b0000, 4'b0000, 1'b0, 1'b0);

    // Watchdog on stage 0
    bus.stall_req = 4'b0001;
`ifdef CORE_PIPE_CTRL_WDOG_EN
    for (int i = 0; i < 7; i++) step();
    chk("wdog_7", 32'(bus.stall_timeout), 32'h0);
    step();
    chk("wdog_8", 32'(bus.stall_timeout), 32'h1);
    bus.stall_req = 4'b0000;
    step();
    step();
    chk("wdog_sticky", 32'(bus.stall_timeout), 32'h1);
    rst_n = 1'b0;
    step();
    chk("wdog_rst", 32'(bus.stall_timeout), 32'h0);
    rst_n = 1'b1;
    step();
`else
    for (int i = 0; i < 20; i++) step();
    chk("wdog_off", 32'(bus.stall_timeout), 32'h0);
    bus.stall_req = 4'b0000;
    step();
    chk("wdog_off_after", 32'(bus.stall_timeout), 32'h0);
`endif
    $display("[TB] wdog stall_timeout=%b", bus.stall_timeout);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
